mod_counter: RTL and testbench

Parametrised up/down modulo counter with synchronous load, a runtime terminal value, and free-running or one-shot mode. It succeeds the fixed 4-bit up-counter as the count core for the clock-generation and distribution path. Its `wrap` pulse is the divide-by-(max_val+1) clock enable for downstream dividers.

---
 rtl/mod_counter_pkg.sv | 20 ++
 rtl/mod_counter.sv | 93 +++++++++
 tb/tb_mod_counter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared constants for the modulo counter
//
// Purpose: state encoding and direction constants used by mod_counter
// and by anything that decodes its behaviour.
// Ports: none (package).

package mod_counter_pkg;

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic {
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT
    } state_e;

endpackage : mod_counter_pkg

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised up/down modulo counter with load and one-shot
//
// Purpose: count core for the clock-generation path. wrap is the
// divide-by-(max_val+1) clock enable for downstream dividers.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset
//   enable   - count advance qualifier
//   up_dn    - direction, 1 = up, 0 = down
//   load     - synchronous load strobe, overrides enable and HALT
//   load_val - value to load (clamped to max_val)
//   max_val  - runtime terminal value, range 0..max_val
//   oneshot  - 1 = halt at terminal, 0 = wrap and continue
//   count    - registered count
//   tc       - combinational terminal-count flag
//   wrap     - registered one-cycle pulse on each wrap or halt event
//   done     - registered, high while halted

module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    // Up mode uses >= so a max_val shrunk below the count still terminates
    // on the next enabled edge instead of running up to 2^WIDTH-1.
    assign tc = (up_dn == DIR_UP) ? (count_q >= max_val)
                                  : (count_q == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        done_d  = done_q;

        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
            state_d = S_RUN;
            done_d  = 1'b0;
        end else if (state_q == S_HALT) begin
            done_d = 1'b1;
        end else if (enable) begin
            if (!tc) begin
                count_d = (up_dn == DIR_UP) ? count_q + WIDTH'(1)
                                            : count_q - WIDTH'(1);
            end else if (!oneshot) begin
                count_d = (up_dn == DIR_UP) ? '0 : max_val;
                wrap_d  = 1'b1;
            end else begin
                state_d = S_HALT;
                done_d  = 1'b1;
                wrap_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            count_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign done  = done_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter

module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] max_val;
    logic       oneshot;
    logic [3:0] count;
    logic       tc;
    logic       wrap;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    mod_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .oneshot  (oneshot),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int c, input int w, input int d);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".wrap"},  32'(wrap),  32'(w));
        check({tag, ".done"},  32'(done),  32'(d));
    endtask

    initial begin
        int exp_c;

        rst      = 1'b0;
        enable   = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        max_val  = 4'd9;
        oneshot  = 1'b0;

        // reset state
        step();
        check_state("reset", 0, 0, 0);
        check("reset.tc", 32'(tc), 32'd0);

        // count to 7, then async reset between edges
        rst    = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 7; i++) step();
        check_state("pre_rst", 7, 0, 0);
        #2 rst = 1'b0;
        #1;
        check_state("async_rst", 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        check_state("post_rst", 1, 0, 0);

        // free-run up, max_val 9, 25 cycles
        load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        check_state("fr_load", 0, 0, 0);
        exp_c = 0;
        for (int k = 1; k <= 25; k++) begin
            check("fr.tc", 32'(tc), (exp_c == 9) ? 32'd1 : 32'd0);
            step();
            exp_c = (exp_c == 9) ? 0 : exp_c + 1;
            check_state("fr", exp_c, (exp_c == 0) ? 1 : 0, 0);
        end
        check("fr.final", 32'(count), 32'd5);

        // down from 2 with max 5, then direction switch
        max_val = 4'd5; load = 1'b1; load_val = 4'd2;
        step();
        load  = 1'b0;
        up_dn = 1'b0;
        #1;
        check("dn.tc2", 32'(tc), 32'd0);
        step(); check_state("dn1", 1, 0, 0);
        step(); check_state("dn0", 0, 0, 0);
        check("dn.tc0", 32'(tc), 32'd1);
        step(); check_state("dn5", 5, 1, 0);
        step(); check_state("dn4", 4, 0, 0);
        up_dn = 1'b1;
        #1;
        check("sw.tc4", 32'(tc), 32'd0);
        step(); check_state("sw5", 5, 0, 0);
        check("sw.tc5", 32'(tc), 32'd1);
        step(); check_state("sw0", 0, 1, 0);

        // one-shot, max 3
        max_val = 4'd3; oneshot = 1'b1; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        check_state("os0", 0, 0, 0);
        step(); check_state("os1", 1, 0, 0);
        step(); check_state("os2", 2, 0, 0);
        step(); check_state("os3", 3, 0, 0);
        step(); check_state("os_halt", 3, 1, 1);
        step(); check_state("os_hold", 3, 0, 1);
        enable = 1'b0;
        step(); check_state("os_en0", 3, 0, 1);
        enable = 1'b1;
        step(); check_state("os_en1", 3, 0, 1);
        load = 1'b1; load_val = 4'd1;
        step();
        load = 1'b0;
        check_state("os_load", 1, 0, 0);
        step(); check_state("os_resume", 2, 0, 0);

        // load clamp and priority over enable
        oneshot = 1'b0; max_val = 4'd10; load = 1'b1; load_val = 4'd14;
        step();
        load = 1'b0;
        check_state("clamp", 10, 0, 0);
        step(); check_state("clamp_wrap", 0, 1, 0);

        // max_val shrink below count
        max_val = 4'd15; load = 1'b1; load_val = 4'd12;
        step();
        load = 1'b0;
        check_state("shr_load", 12, 0, 0);
        max_val = 4'd4;
        #1;
        check("shr.tc", 32'(tc), 32'd1);
        step(); check_state("shr_wrap", 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            step(); check_state("shr_run", k, 0, 0);
        end
        step(); check_state("shr_wrap2", 0, 1, 0);

        // max_val 0: wrap every cycle
        max_val = 4'd0;
        step(); check_state("mz1", 0, 1, 0);
        step(); check_state("mz2", 0, 1, 0);
        enable = 1'b0;
        step(); check_state("mz_off", 0, 0, 0);

        // down mode with count above max_val decrements normally
        enable = 1'b1; max_val = 4'd15; load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; max_val = 4'd3; up_dn = 1'b0;
        step(); check_state("dn_above", 8, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mod_counter
